// File: rtl/axi4l_to_wishbone.sv
// AXI4-Lite responder that drives a single-outstanding Wishbone master.
// One transaction in flight; reads and writes alternate under contention,
// and an optional ack timeout answers with SLVERR.
module axi4l_to_wishbone #(
    parameter int unsigned AXI4L_ADDR_WIDTH = 40,
    parameter int unsigned AXI4L_DATA_SIZE  = 3,
    parameter int unsigned AXI4L_DATA_WIDTH = (8 << AXI4L_DATA_SIZE),
    parameter int unsigned AXI4L_STRB_WIDTH = (1 << AXI4L_DATA_SIZE),
    parameter int unsigned WB_ADR_WIDTH     = AXI4L_ADDR_WIDTH - AXI4L_DATA_SIZE,
    parameter int unsigned TIMEOUT          = 0
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic [AXI4L_ADDR_WIDTH-1:0] s_axi4l_awaddr,
    input  logic [2:0]                  s_axi4l_awprot,
    input  logic                        s_axi4l_awvalid,
    output logic                        s_axi4l_awready,

    input  logic [AXI4L_DATA_WIDTH-1:0] s_axi4l_wdata,
    input  logic [AXI4L_STRB_WIDTH-1:0] s_axi4l_wstrb,
    input  logic                        s_axi4l_wvalid,
    output logic                        s_axi4l_wready,

    output logic [1:0]                  s_axi4l_bresp,
    output logic                        s_axi4l_bvalid,
    input  logic                        s_axi4l_bready,

    input  logic [AXI4L_ADDR_WIDTH-1:0] s_axi4l_araddr,
    input  logic [2:0]                  s_axi4l_arprot,
    input  logic                        s_axi4l_arvalid,
    output logic                        s_axi4l_arready,

    output logic [AXI4L_DATA_WIDTH-1:0] s_axi4l_rdata,
    output logic [1:0]                  s_axi4l_rresp,
    output logic                        s_axi4l_rvalid,
    input  logic                        s_axi4l_rready,

    output logic [WB_ADR_WIDTH-1:0]     m_wb_adr_o,
    output logic [AXI4L_DATA_WIDTH-1:0] m_wb_dat_o,
    input  logic [AXI4L_DATA_WIDTH-1:0] m_wb_dat_i,
    output logic [AXI4L_STRB_WIDTH-1:0] m_wb_sel_o,
    output logic                        m_wb_we_o,
    output logic                        m_wb_stb_o,
    input  logic                        m_wb_ack_i
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Counter sized to hold TIMEOUT; one bit minimum so TIMEOUT=0 still elaborates.
    localparam int unsigned TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        StIdle,
        StWbWr,
        StBResp,
        StWbRd,
        StRResp
    } state_t;

    state_t                      r_state;
    logic                        r_aw_held;
    logic                        r_w_held;
    logic                        r_prio_rd;
    logic [AXI4L_ADDR_WIDTH-1:0] r_aw_addr;
    logic [AXI4L_DATA_WIDTH-1:0] r_wdata;
    logic [AXI4L_STRB_WIDTH-1:0] r_wstrb;
    logic [TO_W-1:0]             r_cnt;

    logic [WB_ADR_WIDTH-1:0]     r_wb_adr;
    logic [AXI4L_DATA_WIDTH-1:0] r_wb_dat;
    logic [AXI4L_STRB_WIDTH-1:0] r_wb_sel;
    logic                        r_wb_we;
    logic                        r_wb_stb;
    logic                        r_bvalid;
    logic [1:0]                  r_bresp;
    logic                        r_rvalid;
    logic [1:0]                  r_rresp;
    logic [AXI4L_DATA_WIDTH-1:0] r_rdata;

    logic                        w_idle;
    logic                        w_rd_prio;
    logic                        w_awready;
    logic                        w_wready;
    logic                        w_arready;
    logic                        w_aw_hs;
    logic                        w_w_hs;
    logic                        w_ar_hs;
    logic                        w_aw_have;
    logic                        w_w_have;
    logic [AXI4L_ADDR_WIDTH-1:0] w_wr_addr;
    logic [AXI4L_DATA_WIDTH-1:0] w_wr_data;
    logic [AXI4L_STRB_WIDTH-1:0] w_wr_strb;
    logic                        w_timeout;
    logic                        w_unused;

    // Protection bits and sub-word address bits carry no meaning on the Wishbone side.
    assign w_unused = ^{s_axi4l_awprot, s_axi4l_arprot,
                        s_axi4l_awaddr[AXI4L_DATA_SIZE-1:0], s_axi4l_araddr[AXI4L_DATA_SIZE-1:0]};

    // Ready generation: combinational from state, held flags and AXI valids only.
    always_comb begin
        w_idle    = (r_state == StIdle) && !reset;
        // A pending read after a write takes the slot and blocks new write captures.
        w_rd_prio = r_prio_rd && s_axi4l_arvalid;
        w_awready = w_idle && !r_aw_held && !w_rd_prio;
        w_wready  = w_idle && !r_w_held && !w_rd_prio;
        w_arready = w_idle && (r_prio_rd ||
                    (!r_aw_held && !r_w_held && !s_axi4l_awvalid && !s_axi4l_wvalid));
        w_aw_hs   = s_axi4l_awvalid && w_awready;
        w_w_hs    = s_axi4l_wvalid && w_wready;
        w_ar_hs   = s_axi4l_arvalid && w_arready;
        w_aw_have = r_aw_held || w_aw_hs;
        w_w_have  = r_w_held || w_w_hs;
        w_wr_addr = r_aw_held ? r_aw_addr : s_axi4l_awaddr;
        w_wr_data = r_w_held ? r_wdata : s_axi4l_wdata;
        w_wr_strb = r_w_held ? r_wstrb : s_axi4l_wstrb;
        w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST);
    end

    assign s_axi4l_awready = w_awready;
    assign s_axi4l_wready  = w_wready;
    assign s_axi4l_arready = w_arready;
    assign s_axi4l_bvalid  = r_bvalid;
    assign s_axi4l_bresp   = r_bresp;
    assign s_axi4l_rvalid  = r_rvalid;
    assign s_axi4l_rresp   = r_rresp;
    assign s_axi4l_rdata   = r_rdata;
    assign m_wb_adr_o      = r_wb_adr;
    assign m_wb_dat_o      = r_wb_dat;
    assign m_wb_sel_o      = r_wb_sel;
    assign m_wb_we_o       = r_wb_we;
    assign m_wb_stb_o      = r_wb_stb;

    // Transaction FSM with all bus outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= StIdle;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_prio_rd <= 1'b0;
            r_aw_addr <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_cnt     <= '0;
            r_wb_adr  <= '0;
            r_wb_dat  <= '0;
            r_wb_sel  <= '0;
            r_wb_we   <= 1'b0;
            r_wb_stb  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_ar_hs) begin
                        // Any half-captured write stays held and is issued after the read.
                        r_state  <= StWbRd;
                        r_wb_adr <= s_axi4l_araddr[AXI4L_ADDR_WIDTH-1:AXI4L_DATA_SIZE];
                        r_wb_dat <= '0;
                        r_wb_sel <= '1;
                        r_wb_we  <= 1'b0;
                        r_wb_stb <= 1'b1;
                        r_cnt    <= '0;
                    end else if (w_aw_have && w_w_have) begin
                        // Address and data both available (held or arriving now): launch.
                        r_state   <= StWbWr;
                        r_wb_adr  <= w_wr_addr[AXI4L_ADDR_WIDTH-1:AXI4L_DATA_SIZE];
                        r_wb_dat  <= w_wr_data;
                        r_wb_sel  <= w_wr_strb;
                        r_wb_we   <= 1'b1;
                        r_wb_stb  <= 1'b1;
                        r_cnt     <= '0;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                    end else begin
                        if (w_aw_hs) begin
                            r_aw_held <= 1'b1;
                            r_aw_addr <= s_axi4l_awaddr;
                        end
                        if (w_w_hs) begin
                            r_w_held <= 1'b1;
                            r_wdata  <= s_axi4l_wdata;
                            r_wstrb  <= s_axi4l_wstrb;
                        end
                    end
                end
                StWbWr: begin
                    if (m_wb_ack_i) begin
                        r_wb_stb <= 1'b0;
                        r_bvalid <= 1'b1;
                        r_bresp  <= RESP_OKAY;
                        r_state  <= StBResp;
                    end else if (w_timeout) begin
                        r_wb_stb <= 1'b0;
                        r_bvalid <= 1'b1;
                        r_bresp  <= RESP_SLVERR;
                        r_state  <= StBResp;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + TO_W'(1);
                    end
                end
                StBResp: begin
                    if (s_axi4l_bready) begin
                        r_bvalid  <= 1'b0;
                        r_prio_rd <= 1'b1;
                        r_state   <= StIdle;
                    end
                end
                StWbRd: begin
                    if (m_wb_ack_i) begin
                        r_wb_stb <= 1'b0;
                        r_rvalid <= 1'b1;
                        r_rresp  <= RESP_OKAY;
                        r_rdata  <= m_wb_dat_i;
                        r_state  <= StRResp;
                    end else if (w_timeout) begin
                        r_wb_stb <= 1'b0;
                        r_rvalid <= 1'b1;
                        r_rresp  <= RESP_SLVERR;
                        r_rdata  <= '0;
                        r_state  <= StRResp;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + TO_W'(1);
                    end
                end
                StRResp: begin
                    if (s_axi4l_rready) begin
                        r_rvalid  <= 1'b0;
                        r_prio_rd <= 1'b0;
                        r_state   <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4l_to_wishbone.sv
// Bench for axi4l_to_wishbone: scoreboard queues filled at issue time, monitors
// compare Wishbone cycles and AXI responses as they appear.
module tb_axi4l_to_wishbone;

    localparam int TO = 16;

    logic        clk;
    logic        reset;
    logic [39:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [36:0] wb_adr;
    logic [63:0] wb_dat_o, wb_dat_i;
    logic [7:0]  wb_sel;
    logic        wb_we, wb_stb, wb_ack;

    axi4l_to_wishbone #(.TIMEOUT(TO)) dut (
        .clk             (clk),
        .reset           (reset),
        .s_axi4l_awaddr  (awaddr),
        .s_axi4l_awprot  (awprot),
        .s_axi4l_awvalid (awvalid),
        .s_axi4l_awready (awready),
        .s_axi4l_wdata   (wdata),
        .s_axi4l_wstrb   (wstrb),
        .s_axi4l_wvalid  (wvalid),
        .s_axi4l_wready  (wready),
        .s_axi4l_bresp   (bresp),
        .s_axi4l_bvalid  (bvalid),
        .s_axi4l_bready  (bready),
        .s_axi4l_araddr  (araddr),
        .s_axi4l_arprot  (arprot),
        .s_axi4l_arvalid (arvalid),
        .s_axi4l_arready (arready),
        .s_axi4l_rdata   (rdata),
        .s_axi4l_rresp   (rresp),
        .s_axi4l_rvalid  (rvalid),
        .s_axi4l_rready  (rready),
        .m_wb_adr_o      (wb_adr),
        .m_wb_dat_o      (wb_dat_o),
        .m_wb_dat_i      (wb_dat_i),
        .m_wb_sel_o      (wb_sel),
        .m_wb_we_o       (wb_we),
        .m_wb_stb_o      (wb_stb),
        .m_wb_ack_i      (wb_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected Wishbone cycle: fields plus how many cycles stb should stay high.
    typedef struct {
        logic [36:0] adr;
        logic        we;
        logic [7:0]  sel;
        logic [63:0] dat;
        int          len;
    } wb_exp_t;
    // Slave behaviour for one cycle: ack after 'delay' wait states, or never.
    typedef struct {
        int          delay;
        bit          noack;
        logic [63:0] rdata;
    } plan_t;
    typedef struct {
        logic [1:0]  resp;
        logic [63:0] data;
    } rsp_t;

    wb_exp_t    q_wb[$];
    plan_t      q_plan[$];
    logic [1:0] q_b[$];
    rsp_t       q_r[$];

    int total = 0;
    int bad   = 0;
    int b_cnt = 0;
    int r_cnt = 0;
    int ready_mode = 0;   // 0: ready high, 1: random, 2: ready low
    bit spurious_en = 0;

    logic [39:0] cw_addr[3], cr_addr[3];
    logic [63:0] cw_data[3], cr_data[3];
    logic [7:0]  cw_strb[3];

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input bit act, input bit exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference model: a write becomes one WB cycle at addr/8 with wstrb lanes.
    task automatic expect_write(input logic [39:0] a, input logic [63:0] d, input logic [7:0] s,
                                input int delay, input bit noack);
        wb_exp_t e;
        plan_t   p;
        e.adr = a[39:3]; e.we = 1'b1; e.sel = s; e.dat = d;
        e.len = noack ? TO : delay + 1;
        p.delay = delay; p.noack = noack; p.rdata = {$urandom, $urandom};
        q_wb.push_back(e);
        q_plan.push_back(p);
        q_b.push_back(noack ? 2'b10 : 2'b00);
    endtask

    task automatic expect_read(input logic [39:0] a, input logic [63:0] d, input int delay,
                               input bit noack);
        wb_exp_t e;
        plan_t   p;
        rsp_t    r;
        e.adr = a[39:3]; e.we = 1'b0; e.sel = 8'hFF; e.dat = 64'h0;
        e.len = noack ? TO : delay + 1;
        p.delay = delay; p.noack = noack; p.rdata = d;
        r.resp = noack ? 2'b10 : 2'b00;
        r.data = noack ? 64'h0 : d;
        q_wb.push_back(e);
        q_plan.push_back(p);
        q_r.push_back(r);
    endtask

    // Drive AW and W; lead>0 puts W that many cycles ahead of AW, lead<0 the reverse.
    task automatic axi_write(input logic [39:0] a, input logic [63:0] d, input logic [7:0] s,
                             input int lead);
        int cyc = 0;
        int aw_start = (lead > 0) ? lead : 0;
        int w_start = (lead < 0) ? -lead : 0;
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        while (!(aw_done && w_done) && cyc < 100) begin
            awaddr = a; wdata = d; wstrb = s;
            awvalid = !aw_done && (cyc >= aw_start);
            wvalid = !w_done && (cyc >= w_start);
            @(negedge clk);
            hs_aw = awvalid && awready;
            hs_w = wvalid && wready;
            if (lead > 0 && !aw_done) check1("no_stb_before_aw", wb_stb, 1'b0);
            @(posedge clk); #1;
            aw_done |= hs_aw;
            w_done |= hs_w;
            cyc++;
        end
        awvalid = 1'b0;
        wvalid = 1'b0;
        check1("write_accepted", aw_done && w_done, 1'b1);
    endtask

    task automatic axi_read(input logic [39:0] a);
        int cyc = 0;
        bit done = 0;
        while (!done && cyc < 100) begin
            araddr = a;
            arvalid = 1'b1;
            @(negedge clk);
            done = arready;
            @(posedge clk); #1;
            cyc++;
        end
        arvalid = 1'b0;
        check1("read_accepted", done, 1'b1);
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while ((q_b.size() != 0 || q_r.size() != 0 || q_wb.size() != 0 || bvalid || rvalid)
               && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check1("drain_in_time", n < limit, 1'b1);
    endtask

    task automatic flush_model();
        q_wb.delete();
        q_plan.delete();
        q_b.delete();
        q_r.delete();
    endtask

    function automatic logic [39:0] rand_addr();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[39:0];
    endfunction

    // AXI response ready generation.
    initial begin
        bready = 1'b0;
        rready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       begin bready = 1'b1; rready = 1'b1; end
                1:       begin bready = 1'($urandom_range(0, 1)); rready = 1'($urandom_range(0, 1)); end
                default: begin bready = 1'b0; rready = 1'b0; end
            endcase
        end
    end

    // Wishbone slave following the plan queue; optional spurious acks while idle.
    initial begin : wb_slave
        plan_t cur;
        bit    busy;
        int    scnt;
        wb_ack = 1'b0;
        wb_dat_i = 64'h0;
        busy = 0;
        scnt = 0;
        cur.delay = 0; cur.noack = 1; cur.rdata = 64'h0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                busy = 0;
                wb_ack = 1'b0;
            end else if (wb_stb) begin
                if (!busy) begin
                    busy = 1;
                    scnt = 0;
                    if (q_plan.size() != 0) cur = q_plan.pop_front();
                    else cur.noack = 1;
                end
                if (!cur.noack && scnt == cur.delay) begin
                    wb_ack = 1'b1;
                    wb_dat_i = cur.rdata;
                end else begin
                    wb_ack = 1'b0;
                    wb_dat_i = {$urandom, $urandom};
                end
                scnt++;
            end else begin
                busy = 0;
                wb_ack = spurious_en && ($urandom_range(0, 3) == 0);
                wb_dat_i = {$urandom, $urandom};
            end
        end
    end

    // Wishbone monitor: fields, stability while stb is high, and stb length.
    initial begin : wb_mon
        bit          in_stb;
        bit          have;
        int          len;
        wb_exp_t     cur;
        logic [109:0] cap;
        in_stb = 0;
        have = 0;
        len = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_stb = 0;
                have = 0;
            end else if (wb_stb) begin
                if (!in_stb) begin
                    in_stb = 1;
                    len = 1;
                    check1("wb_cycle_expected", q_wb.size() != 0, 1'b1);
                    have = (q_wb.size() != 0);
                    if (have) begin
                        cur = q_wb.pop_front();
                        check64("wb_adr", 64'(wb_adr), 64'(cur.adr));
                        check1("wb_we", wb_we, cur.we);
                        check64("wb_sel", 64'(wb_sel), 64'(cur.sel));
                        if (cur.we) check64("wb_dat", wb_dat_o, cur.dat);
                    end
                    cap = {wb_adr, wb_we, wb_sel, wb_dat_o};
                end else begin
                    len++;
                    check1("wb_stable", cap == {wb_adr, wb_we, wb_sel, wb_dat_o}, 1'b1);
                end
            end else if (in_stb) begin
                in_stb = 0;
                if (have) check64("wb_stb_len", 64'(len), 64'(cur.len));
                have = 0;
            end
        end
    end

    // AXI response monitor.
    initial begin : rsp_mon
        rsp_t r;
        logic [1:0] b;
        forever begin
            @(negedge clk);
            if (!reset && bvalid && bready) begin
                check1("b_expected", q_b.size() != 0, 1'b1);
                if (q_b.size() != 0) begin
                    b = q_b.pop_front();
                    check64("bresp", 64'(bresp), 64'(b));
                end
                b_cnt++;
            end
            if (!reset && rvalid && rready) begin
                check1("r_expected", q_r.size() != 0, 1'b1);
                if (q_r.size() != 0) begin
                    r = q_r.pop_front();
                    check64("rresp", 64'(rresp), 64'(r.resp));
                    check64("rdata", rdata, r.data);
                end
                r_cnt++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [39:0] a;
        logic [63:0] d;
        int          n;
        reset = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0;

        // Readies must stay low under reset even with valids pending.
        repeat (2) @(posedge clk);
        #1;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(negedge clk);
        check1("rst_awready", awready, 1'b0);
        check1("rst_wready", wready, 1'b0);
        check1("rst_arready", arready, 1'b0);
        check1("rst_stb", wb_stb, 1'b0);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check1("idle_awready", awready, 1'b1);
        check1("idle_arready", arready, 1'b1);
        check1("idle_bvalid", bvalid, 1'b0);
        check1("idle_rvalid", rvalid, 1'b0);
        check64("idle_adr", 64'(wb_adr), 64'h0);
        check64("idle_rdata", rdata, 64'h0);

        // Zero-wait write, AW and W together: stb in cycle 1, bvalid in cycle 2.
        @(posedge clk); #1;
        expect_write(40'h00_0000_0040, 64'h1122334455667788, 8'hFF, 0, 0);
        axi_write(40'h00_0000_0040, 64'h1122334455667788, 8'hFF, 0);
        @(negedge clk);
        check1("wr_lat_stb", wb_stb, 1'b1);
        check64("wr_lat_adr", 64'(wb_adr), 64'h8);
        @(negedge clk);
        check1("wr_lat_bvalid", bvalid, 1'b1);
        wait_done(50);

        // W three cycles ahead of AW with partial strobe.
        expect_write(40'h00_0000_2000, 64'hA5A5_0102_0304_5A5A, 8'h0F, 1, 0);
        axi_write(40'h00_0000_2000, 64'hA5A5_0102_0304_5A5A, 8'h0F, 3);
        wait_done(50);

        // Read with four wait states.
        expect_read(40'h00_0000_0100, 64'hDEADBEEFCAFEF00D, 4, 0);
        axi_read(40'h00_0000_0100);
        wait_done(50);

        // Zero-wait read latency: stb in cycle 1, rvalid in cycle 2.
        expect_read(40'h00_0000_0208, 64'h0123_4567_89AB_CDEF, 0, 0);
        axi_read(40'h00_0000_0208);
        @(negedge clk);
        check1("rd_lat_stb", wb_stb, 1'b1);
        @(negedge clk);
        check1("rd_lat_rvalid", rvalid, 1'b1);
        wait_done(50);

        // Writes and reads contending: first write wins, then strict alternation.
        for (int i = 0; i < 3; i++) begin
            cw_addr[i] = rand_addr(); cw_data[i] = {$urandom, $urandom};
            cw_strb[i] = 8'($urandom_range(1, 255));
            cr_addr[i] = rand_addr(); cr_data[i] = {$urandom, $urandom};
            expect_write(cw_addr[i], cw_data[i], cw_strb[i], i, 0);
            expect_read(cr_addr[i], cr_data[i], 2 - i, 0);
        end
        fork
            begin : writer
                int base = b_cnt;
                for (int i = 0; i < 3; i++) begin
                    int k = 0;
                    axi_write(cw_addr[i], cw_data[i], cw_strb[i], 0);
                    while (b_cnt < base + i + 1 && k < 200) begin
                        @(posedge clk); #1;
                        k++;
                    end
                    check1("alt_b_in_time", k < 200, 1'b1);
                end
            end
            begin : reader
                int base = r_cnt;
                for (int i = 0; i < 3; i++) begin
                    int k = 0;
                    axi_read(cr_addr[i]);
                    while (r_cnt < base + i + 1 && k < 200) begin
                        @(posedge clk); #1;
                        k++;
                    end
                    check1("alt_r_in_time", k < 200, 1'b1);
                end
            end
        join
        wait_done(50);

        // Timeouts: read and write never acked, then a normal read.
        expect_read(40'h00_0000_0300, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
        axi_read(40'h00_0000_0300);
        wait_done(100);
        expect_write(40'h00_0000_0308, 64'h5555_AAAA_5555_AAAA, 8'h3C, 0, 1);
        axi_write(40'h00_0000_0308, 64'h5555_AAAA_5555_AAAA, 8'h3C, 0);
        wait_done(100);
        expect_read(40'h00_0000_0310, 64'h0F0F_0F0F_F0F0_F0F0, 1, 0);
        axi_read(40'h00_0000_0310);
        wait_done(50);

        // Randomized sequential traffic with random ready and spurious acks.
        ready_mode = 1;
        spurious_en = 1;
        for (int i = 0; i < 30; i++) begin
            int  dly = int'($urandom_range(0, 5));
            bit  na = ($urandom_range(0, 9) == 0);
            a = rand_addr();
            d = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                logic [7:0] s = 8'($urandom);
                int lead = int'($urandom_range(0, 6)) - 3;
                expect_write(a, d, s, dly, na);
                axi_write(a, d, s, lead);
            end else begin
                expect_read(a, d, dly, na);
                axi_read(a);
            end
            wait_done(200);
        end
        ready_mode = 0;
        spurious_en = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset during a read's Wishbone cycle.
        expect_read(40'h00_0000_0400, 64'h1, 0, 1);
        axi_read(40'h00_0000_0400);
        n = 0;
        while (!wb_stb && n < 20) begin
            @(negedge clk);
            n++;
        end
        check1("rst_rd_stb_seen", wb_stb, 1'b1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check1("rst_rd_stb_drop", wb_stb, 1'b0);
        check1("rst_rd_arready", arready, 1'b0);
        flush_model();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check1("rst_rd_no_stale", rvalid, 1'b0);
        @(posedge clk); #1;
        expect_read(40'h00_0000_0408, 64'hBEEF_0000_1234_5678, 2, 0);
        axi_read(40'h00_0000_0408);
        wait_done(50);

        // Reset while a write response waits on bready.
        ready_mode = 2;
        expect_write(40'h00_0000_0500, 64'h77, 8'h01, 0, 0);
        axi_write(40'h00_0000_0500, 64'h77, 8'h01, 0);
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check1("rst_b_bvalid_seen", bvalid, 1'b1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check1("rst_b_bvalid_drop", bvalid, 1'b0);
        check1("rst_b_awready", awready, 1'b0);
        flush_model();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        ready_mode = 0;
        repeat (10) @(negedge clk);
        check1("rst_b_no_stale", bvalid, 1'b0);
        @(posedge clk); #1;
        expect_read(40'h00_0000_0508, 64'hCAFE_BABE_0000_FFFF, 0, 0);
        axi_read(40'h00_0000_0508);
        wait_done(50);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
